// File: rtl/div_pkg.sv
// Shared types and constants for the iterative 32-bit divider.
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

    localparam int unsigned DIV_WIDTH     = 32;
    localparam logic [4:0]  DIV_ITER_LAST = 5'd31;
    localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFFFFFF;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit and
// conditionally subtract the divisor.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             dividend_msb_i,
    output logic [WIDTH:0]   next_rem_o,
    output logic             q_bit_o
);

    localparam int unsigned RW = WIDTH + 1;
    localparam int unsigned SW = WIDTH + 2;

    logic [SW-1:0] shifted_c;
    logic [SW-1:0] divisor_ext_c;

    always_comb begin
        shifted_c     = {rem_i, dividend_msb_i};
        divisor_ext_c = {2'b00, divisor_i};
        q_bit_o       = 1'b0;
        next_rem_o    = RW'(shifted_c);
        if (shifted_c >= divisor_ext_c) begin
            q_bit_o    = 1'b1;
            next_rem_o = RW'(shifted_c - divisor_ext_c);
        end
    end

endmodule

// File: rtl/div32_iterative.sv
// Multi-cycle signed/unsigned divider producing MIPS-style HI/LO results
// (LO = quotient, HI = remainder), one restoring step per cycle.
module div32_iterative
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic             Signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] LoResult,
    output logic [WIDTH-1:0] HiResult,
    output logic             DivByZero
);

    localparam int unsigned      CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ZERO_QUOT = {WIDTH{1'b1}};

    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dsr_q;
    logic             qneg_q;
    logic             rneg_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_q;

    logic             accept_c;
    logic             a_neg_c;
    logic             b_neg_c;
    logic [WIDTH-1:0] a_mag_c;
    logic [WIDTH-1:0] b_mag_c;
    logic [WIDTH:0]   step_rem_c;
    logic             step_q_c;

    // Operand conditioning: magnitudes only matter for signed divides.
    always_comb begin
        accept_c = Start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        a_neg_c  = Signed & A[WIDTH-1];
        b_neg_c  = Signed & B[WIDTH-1];
        a_mag_c  = a_neg_c ? -A : A;
        b_mag_c  = b_neg_c ? -B : B;
    end

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_i         (rem_q),
        .divisor_i     (dsr_q),
        .dividend_msb_i(dvd_q[WIDTH-1]),
        .next_rem_o    (step_rem_c),
        .q_bit_o       (step_q_c)
    );

    // The dividend register doubles as the quotient: dividend bits shift out
    // the top while quotient bits shift in at the bottom.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            done_q <= 1'b0;

            case (state_q)
                ST_RUN: begin
                    rem_q <= step_rem_c;
                    dvd_q <= {dvd_q[WIDTH-2:0], step_q_c};
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == ITER_LAST) begin
                        state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    lo_q    <= qneg_q ? -dvd_q : dvd_q;
                    hi_q    <= WIDTH'(rneg_q ? -rem_q : rem_q);
                    dbz_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                end
            endcase

            // Acceptance only happens in IDLE/DONE, so it never races the RUN/FIX arms.
            if (accept_c) begin
                if (B == '0) begin
                    lo_q    <= ZERO_QUOT;
                    hi_q    <= A;
                    dbz_q   <= 1'b1;
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end else begin
                    rem_q   <= '0;
                    cnt_q   <= '0;
                    dvd_q   <= a_mag_c;
                    dsr_q   <= b_mag_c;
                    qneg_q  <= a_neg_c ^ b_neg_c;
                    rneg_q  <= a_neg_c;
                    busy_q  <= 1'b1;
                    state_q <= ST_RUN;
                end
            end
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign LoResult  = lo_q;
    assign HiResult  = hi_q;
    assign DivByZero = dbz_q;

endmodule

// File: tb/tb_div32_iterative.sv
// Self-checking bench for div32_iterative: directed cases plus random
// operands against an arithmetic reference model.
module tb_div32_iterative;
    import div_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Start;
    logic        Signed;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic        Done;
    logic [31:0] LoResult;
    logic [31:0] HiResult;
    logic        DivByZero;

    int errors = 0;
    int checks = 0;

    div32_iterative #(.WIDTH(32)) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Start    (Start),
        .Signed   (Signed),
        .A        (A),
        .B        (B),
        .Busy     (Busy),
        .Done     (Done),
        .LoResult (LoResult),
        .HiResult (HiResult),
        .DivByZero(DivByZero)
    );

    always #5 Clk = ~Clk;

    // Reference: MIPS DIV/DIVU semantics via wide host arithmetic.
    function automatic void ref_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] lo, output logic [31:0] hi,
                                    output logic dbz);
        longint sa, sb, q, r;
        if (b == 32'd0) begin
            lo  = DIV_ZERO_QUOT;
            hi  = a;
            dbz = 1'b1;
        end else if (s) begin
            sa  = longint'($signed(a));
            sb  = longint'($signed(b));
            q   = sa / sb;
            r   = sa % sb;
            lo  = q[31:0];
            hi  = r[31:0];
            dbz = 1'b0;
        end else begin
            lo  = a / b;
            hi  = a % b;
            dbz = 1'b0;
        end
    endfunction

    // Called at a falling edge; the request is taken on the following rising edge.
    task automatic issue_start(input bit s, input logic [31:0] a, input logic [31:0] b);
        Start  = 1'b1;
        Signed = s;
        A      = a;
        B      = b;
        @(posedge Clk);
        @(negedge Clk);
        Start  = 1'b0;
        A      = $urandom;
        B      = $urandom;
    endtask

    // Measures cycles until Done; n is the cycle index relative to the start edge.
    task automatic wait_done(input int n0, output int n, output int busy_cnt,
                             output bit overlap, output bit moved);
        logic [31:0] lo0, hi0;
        lo0 = LoResult;
        hi0 = HiResult;
        n = n0;
        busy_cnt = 0;
        overlap = 1'b0;
        moved = 1'b0;
        while (Done !== 1'b1 && n < 60) begin
            if (Busy === 1'b1) busy_cnt++;
            if (LoResult !== lo0 || HiResult !== hi0) moved = 1'b1;
            @(negedge Clk);
            n++;
        end
        if (Busy === 1'b1 && Done === 1'b1) overlap = 1'b1;
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        repeat (2) @(negedge Clk);
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
        checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", Done); end
        checks++; if (LoResult !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h want 0", LoResult); end
        checks++; if (HiResult !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h want 0", HiResult); end
        checks++; if (DivByZero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b want 0", DivByZero); end
        Rst_n = 1'b1;
        @(negedge Clk);
    endtask

    task automatic test_directed();
        bit          ts [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] ta [7] = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'hFFFFFFF9, 32'h80000000, 32'hFFFFFFFF, 32'd5};
        logic [31:0] tb [7] = '{32'd7, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd1, 32'd9};
        logic [31:0] tl [7] = '{32'd14, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0};
        logic [31:0] th [7] = '{32'd2, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd5};
        int n, bc;
        bit ov, mv;
        for (int i = 0; i < 7; i++) begin
            issue_start(ts[i], ta[i], tb[i]);
            wait_done(1, n, bc, ov, mv);
            checks++; if (n != 34) begin errors++; $display("FAIL dir%0d_latency: got %0d want 34", i, n); end
            checks++; if (bc != 33) begin errors++; $display("FAIL dir%0d_busy_cycles: got %0d want 33", i, bc); end
            checks++; if (ov) begin errors++; $display("FAIL dir%0d_busy_done_overlap: got 1 want 0", i); end
            checks++; if (LoResult !== tl[i]) begin errors++; $display("FAIL dir%0d_lo: got %h want %h", i, LoResult, tl[i]); end
            checks++; if (HiResult !== th[i]) begin errors++; $display("FAIL dir%0d_hi: got %h want %h", i, HiResult, th[i]); end
            checks++; if (DivByZero !== 1'b0) begin errors++; $display("FAIL dir%0d_dbz: got %b want 0", i, DivByZero); end
        end
    endtask

    task automatic test_div_by_zero();
        int n, bc;
        bit ov, mv;
        for (int s = 0; s < 2; s++) begin
            issue_start(s[0], 32'h1234, 32'd0);
            wait_done(1, n, bc, ov, mv);
            checks++; if (n != 1) begin errors++; $display("FAIL dbz%0d_latency: got %0d want 1", s, n); end
            checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL dbz%0d_busy: got %b want 0", s, Busy); end
            checks++; if (LoResult !== 32'hFFFFFFFF) begin errors++; $display("FAIL dbz%0d_lo: got %h want ffffffff", s, LoResult); end
            checks++; if (HiResult !== 32'h1234) begin errors++; $display("FAIL dbz%0d_hi: got %h want 1234", s, HiResult); end
            checks++; if (DivByZero !== 1'b1) begin errors++; $display("FAIL dbz%0d_flag: got %b want 1", s, DivByZero); end
            @(negedge Clk);
            checks++; if (Done !== 1'b0) begin errors++; $display("FAIL dbz%0d_done_pulse: got %b want 0", s, Done); end
        end
        issue_start(1'b0, 32'd20, 32'd3);
        wait_done(1, n, bc, ov, mv);
        checks++; if (DivByZero !== 1'b0) begin errors++; $display("FAIL dbz_clear: got %b want 0", DivByZero); end
        checks++; if (LoResult !== 32'd6 || HiResult !== 32'd2) begin
            errors++; $display("FAIL dbz_after_div: got lo=%h hi=%h want lo=6 hi=2", LoResult, HiResult);
        end
    endtask

    task automatic test_handshake();
        int n, bc;
        bit ov, mv;
        issue_start(1'b0, 32'd1000, 32'd7);
        repeat (4) @(negedge Clk);
        // Stray request with a zero divisor would short-circuit if not ignored.
        Start = 1'b1; Signed = 1'b1; A = 32'd1; B = 32'd0;
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        wait_done(6, n, bc, ov, mv);
        checks++; if (n != 34) begin errors++; $display("FAIL hs_ignore_latency: got %0d want 34", n); end
        checks++; if (bc != 28) begin errors++; $display("FAIL hs_ignore_busy: got %0d want 28", bc); end
        checks++; if (mv) begin errors++; $display("FAIL hs_result_hold: results changed during run"); end
        checks++; if (LoResult !== 32'd142 || HiResult !== 32'd6 || DivByZero !== 1'b0) begin
            errors++; $display("FAIL hs_ignore_result: got lo=%h hi=%h dbz=%b want lo=8e hi=6 dbz=0", LoResult, HiResult, DivByZero);
        end
        issue_start(1'b1, 32'hFFFFFF9C, 32'd9);
        checks++; if (Busy !== 1'b1 || Done !== 1'b0) begin
            errors++; $display("FAIL b2b_busy_rise: got busy=%b done=%b want busy=1 done=0", Busy, Done);
        end
        wait_done(1, n, bc, ov, mv);
        checks++; if (n != 34) begin errors++; $display("FAIL b2b_latency: got %0d want 34", n); end
        checks++; if (LoResult !== 32'hFFFFFFF5 || HiResult !== 32'hFFFFFFFF) begin
            errors++; $display("FAIL b2b_result: got lo=%h hi=%h want lo=fffffff5 hi=ffffffff", LoResult, HiResult);
        end
    endtask

    task automatic test_reset_mid_run();
        int n, bc;
        bit ov, mv, seen;
        issue_start(1'b0, 32'hFFFF0000, 32'd3);
        repeat (9) @(negedge Clk);
        Rst_n = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        checks++; if (Busy !== 1'b0 || Done !== 1'b0 || LoResult !== 32'd0 || HiResult !== 32'd0 || DivByZero !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs: got busy=%b done=%b lo=%h hi=%h dbz=%b want all 0",
                               Busy, Done, LoResult, HiResult, DivByZero);
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (Done === 1'b1 || Busy === 1'b1) seen = 1'b1;
            @(negedge Clk);
        end
        checks++; if (seen) begin errors++; $display("FAIL midrst_no_done: got activity after reset want none"); end
        issue_start(1'b0, 32'd9, 32'd3);
        wait_done(1, n, bc, ov, mv);
        checks++; if (n != 34) begin errors++; $display("FAIL midrst_next_latency: got %0d want 34", n); end
        checks++; if (LoResult !== 32'd3 || HiResult !== 32'd0) begin
            errors++; $display("FAIL midrst_next_result: got lo=%h hi=%h want lo=3 hi=0", LoResult, HiResult);
        end
    endtask

    task automatic test_random();
        int n, bc;
        bit ov, mv, s;
        logic [31:0] a, b, elo, ehi;
        logic edbz;
        for (int i = 0; i < 30; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'($urandom_range(1, 15));
                1: b = 32'd0;
                2: b = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
                3: b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            ref_div(s, a, b, elo, ehi, edbz);
            issue_start(s, a, b);
            wait_done(1, n, bc, ov, mv);
            checks++; if (n != ((b == 32'd0) ? 1 : 34)) begin errors++; $display("FAIL rnd%0d_latency: got %0d", i, n); end
            checks++; if (ov) begin errors++; $display("FAIL rnd%0d_overlap: busy and done both high", i); end
            checks++; if (LoResult !== elo || HiResult !== ehi || DivByZero !== edbz) begin
                errors++; $display("FAIL rnd%0d_result s=%0d a=%h b=%h: got lo=%h hi=%h dbz=%b want lo=%h hi=%h dbz=%b",
                                   i, s, a, b, LoResult, HiResult, DivByZero, elo, ehi, edbz);
            end
        end
    endtask

    initial begin
        Rst_n  = 1'b0;
        Start  = 1'b0;
        Signed = 1'b0;
        A      = 32'd0;
        B      = 32'd0;
        @(negedge Clk);
        test_reset();
        test_directed();
        test_div_by_zero();
        test_handshake();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
